// File: rtl/seg7_pkg.sv
// Seven-segment pattern constants (a..g order, a is the MSB) and the shared
// code-to-pattern lookup used by the scan driver's decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // Codes 10-15 only light up in hex mode; otherwise they read as blank.
    function automatic logic [6:0] seg7_code(input logic [3:0] code,
                                             input logic       hex_mode,
                                             input logic       blank);
        logic [6:0] pat;
        pat = SEG_OFF;
        if (!blank) begin
            case (code)
                4'h0: pat = SEG_0;
                4'h1: pat = SEG_1;
                4'h2: pat = SEG_2;
                4'h3: pat = SEG_3;
                4'h4: pat = SEG_4;
                4'h5: pat = SEG_5;
                4'h6: pat = SEG_6;
                4'h7: pat = SEG_7;
                4'h8: pat = SEG_8;
                4'h9: pat = SEG_9;
                4'hA: pat = hex_mode ? SEG_A : SEG_OFF;
                4'hB: pat = hex_mode ? SEG_B : SEG_OFF;
                4'hC: pat = hex_mode ? SEG_C : SEG_OFF;
                4'hD: pat = hex_mode ? SEG_D : SEG_OFF;
                4'hE: pat = hex_mode ? SEG_E : SEG_OFF;
                4'hF: pat = hex_mode ? SEG_F : SEG_OFF;
            endcase
        end
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decoder for the digit currently being scanned.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [1:7] seg
);

    assign seg = seg7_code(code, hex_mode, blank);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-cathode display driver: prescaled digit scan, frame-aligned
// double-buffered loads, leading-zero blanking and registered pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic [NUM_DIGITS-1:0]   load_dp,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    output logic [1:7]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   dig_en
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0] active_data_q, active_data_d;
    logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
    logic [1:7]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   dig_en_q, dig_en_d;

    logic                    tick;
    logic                    frame_end;
    logic                    accept;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   dig_onehot;
    logic [3:0]              cur_code;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [1:7]              dec_seg;

    assign tick       = (cnt_q == CNT_LAST);
    assign frame_end  = tick && (idx_q == IDX_LAST);
    assign accept     = load_valid && !pending_q;
    assign load_ready = !pending_q;

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_ONE;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        end
    end

    // The held value moves to the display only at a frame boundary, so a
    // frame never mixes digits from two different loads.
    always_comb begin
        pending_d     = pending_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        active_data_d = active_data_q;
        active_dp_d   = active_dp_q;
        if (frame_end && pending_q) begin
            active_data_d = pend_data_q;
            active_dp_d   = pend_dp_q;
            pending_d     = 1'b0;
        end
        if (accept) begin
            pend_data_d = load_data;
            pend_dp_d   = load_dp;
            pending_d   = 1'b1;
        end
    end

    // A digit is blanked when it and every digit above it are zero; digit 0
    // always stays lit so an all-zero value still reads "0".
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (active_data_q[4*i +: 4] == 4'h0);
            lz_mask[i] = blank_lz && zero_run && (i != 0);
        end
    end

    always_comb begin
        cur_code   = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        dig_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_code      = active_data_q[4*i +: 4];
                cur_dp        = active_dp_q[i];
                cur_blank     = lz_mask[i];
                dig_onehot[i] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .code     (cur_code),
        .hex_mode (hex_mode),
        .blank    (cur_blank),
        .seg      (dec_seg)
    );

    // The first cycle of every slot keeps all digits off so the previous
    // digit's segments do not ghost onto the next one.
    always_comb begin
        seg_d    = dec_seg;
        dp_d     = (cnt_q == '0) ? 1'b0 : cur_dp;
        dig_en_d = (cnt_q == '0) ? '0 : dig_onehot;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            active_data_q <= '0;
            active_dp_q   <= '0;
            seg_q         <= '0;
            dp_q          <= 1'b0;
            dig_en_q      <= '0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            pending_q     <= pending_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            active_data_q <= active_data_d;
            active_dp_q   <= active_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dig_en_q      <= dig_en_d;
        end
    end

    assign seg    = seg_q;
    assign dp     = dp_q;
    assign dig_en = dig_en_q;

endmodule
